// File: rtl/mem_arbiter_if.sv
// Cache/memory bus shared by the I-cache, D-cache and main memory around mem_arbiter.
// The slave modport is the arbiter's view; master is the caches-plus-memory environment.
interface mem_arbiter_if;
  logic        i_req;
  logic        i_wr;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic        i_grant;
  logic        i_ready;
  logic        i_rvalid;
  logic [15:0] i_rdata;

  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_grant;
  logic        d_ready;
  logic        d_rvalid;
  logic [15:0] d_rdata;

  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;

  logic        err;

  modport slave (
    input  i_req, i_wr, i_addr, i_wdata,
    input  d_req, d_wr, d_addr, d_wdata,
    input  mem_data_out, mem_data_valid,
    output i_grant, i_ready, i_rvalid, i_rdata,
    output d_grant, d_ready, d_rvalid, d_rdata,
    output mem_enable, mem_wr, mem_addr, mem_data_in,
    output err
  );

  modport master (
    output i_req, i_wr, i_addr, i_wdata,
    output d_req, d_wr, d_addr, d_wdata,
    output mem_data_out, mem_data_valid,
    input  i_grant, i_ready, i_rvalid, i_rdata,
    input  d_grant, d_ready, d_rvalid, d_rdata,
    input  mem_enable, mem_wr, mem_addr, mem_data_in,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares main memory between the I-cache and D-cache: one owner at a time, pipelined
// reads tracked by an outstanding counter, returning words routed to the last owner.
module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_e;
  typedef enum logic {SIDE_I, SIDE_D} side_e;

  state_e           state_q, state_d;
  side_e            last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic grant_i, grant_d, ready_i, ready_d;
  logic room, read_issue, ret;

  assign grant_i    = (state_q == OWN_I);
  assign grant_d    = (state_q == OWN_D);
  // A returning word frees a slot in the same cycle, so a full pipeline can keep streaming.
  assign room       = (count_q < CNT_W'(MAX_OUTSTANDING)) || bus.mem_data_valid;
  assign ready_i    = grant_i && bus.i_req && (bus.i_wr || room);
  assign ready_d    = grant_d && bus.d_req && (bus.d_wr || room);
  assign read_issue = (ready_i && !bus.i_wr) || (ready_d && !bus.d_wr);
  assign ret        = bus.mem_data_valid && (count_q != '0);

  assign bus.i_grant     = grant_i;
  assign bus.d_grant     = grant_d;
  assign bus.i_ready     = ready_i;
  assign bus.d_ready     = ready_d;
  assign bus.mem_enable  = ready_i || ready_d;
  assign bus.mem_wr      = (ready_i && bus.i_wr) || (ready_d && bus.d_wr);
  assign bus.mem_addr    = ready_i ? bus.i_addr  : (ready_d ? bus.d_addr  : 16'h0000);
  assign bus.mem_data_in = ready_i ? bus.i_wdata : (ready_d ? bus.d_wdata : 16'h0000);

  // Ownership only changes through IDLE after a full drain, so the last owner is the route.
  assign bus.i_rvalid = ret && (last_q == SIDE_I);
  assign bus.d_rvalid = ret && (last_q == SIDE_D);
  assign bus.i_rdata  = bus.mem_data_out;
  assign bus.d_rdata  = bus.mem_data_out;
  assign bus.err      = err_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.d_req && (!bus.i_req || last_q == SIDE_I)) begin
          state_d = OWN_D;
          last_d  = SIDE_D;
        end else if (bus.i_req) begin
          state_d = OWN_I;
          last_d  = SIDE_I;
        end
      end
      OWN_I: if (!bus.i_req) state_d = (count_q == '0) ? IDLE : DRAIN;
      OWN_D: if (!bus.d_req) state_d = (count_q == '0) ? IDLE : DRAIN;
      DRAIN: if (count_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case ({read_issue, ret})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus.mem_data_valid && count_q == '0 && state_q != IDLE) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SIDE_I;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked against a
// transaction-level model (owner, queue of pending reads tagged by issuer) and a latency memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int tag; logic [15:0] data;} rd_t;
  typedef struct {int due; logic [15:0] data;} mret_t;

  int checks = 0;
  int errors = 0;

  // Reference model: holder 0=none 1=I 2=D; pend holds reads in flight oldest first.
  int    holder, last;
  bit    draining, err_m;
  rd_t   pend[$];
  mret_t mq[$];
  logic [15:0] mem_arr [0:1023];
  int    cyc = 0;
  int    lat = 4;
  bit    inject = 0;
  int    rvi = 0, rvd = 0;

  bit          e_ri, e_rd, e_iw, e_mv, e_ret;
  int          e_cnt;
  logic [15:0] e_ea, e_ewd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive memory for this cycle, then compare every DUT output with the model.
  task automatic eval();
    logic [15:0] md;
    bit gi, gd;
    int ti;
    md   = 16'($urandom);
    e_mv = 1'b0;
    if (inject) e_mv = 1'b1;
    else if (mq.size() > 0 && mq[0].due <= cyc) begin
      e_mv = 1'b1;
      md   = mq[0].data;
      void'(mq.pop_front());
    end
    bus.mem_data_valid = e_mv;
    bus.mem_data_out   = md;
    #1;
    e_cnt = pend.size();
    gi    = (holder == 1) && !draining;
    gd    = (holder == 2) && !draining;
    e_ri  = gi && bus.i_req && (bus.i_wr || e_cnt < 4 || e_mv);
    e_rd  = gd && bus.d_req && (bus.d_wr || e_cnt < 4 || e_mv);
    e_iw  = (e_ri && bus.i_wr) || (e_rd && bus.d_wr);
    e_ea  = e_ri ? bus.i_addr  : (e_rd ? bus.d_addr  : 16'h0000);
    e_ewd = e_ri ? bus.i_wdata : (e_rd ? bus.d_wdata : 16'h0000);
    e_ret = e_mv && e_cnt > 0;
    ti    = e_ret ? pend[0].tag : 0;

    chk("i_grant", bus.i_grant, gi);
    chk("d_grant", bus.d_grant, gd);
    chk("i_ready", bus.i_ready, e_ri);
    chk("d_ready", bus.d_ready, e_rd);
    chk("mem_enable", bus.mem_enable, e_ri || e_rd);
    chk("mem_wr", bus.mem_wr, e_iw);
    chk("mem_addr", bus.mem_addr, e_ea);
    chk("mem_data_in", bus.mem_data_in, e_ewd);
    chk("i_rvalid", bus.i_rvalid, ti == 1);
    chk("d_rvalid", bus.d_rvalid, ti == 2);
    if (ti == 1) chk("i_rdata", bus.i_rdata, pend[0].data);
    if (ti == 2) chk("d_rdata", bus.d_rdata, pend[0].data);
    chk("err", bus.err, err_m);
    if (bus.i_rvalid === 1'b1) rvi++;
    if (bus.d_rvalid === 1'b1) rvd++;
  endtask

  // Apply this cycle's transaction to the model and move to the next cycle.
  task automatic advance();
    int pick;
    bit own_req;
    if (e_mv && e_cnt == 0 && holder != 0) err_m = 1'b1;
    if (e_ret) void'(pend.pop_front());
    if ((e_ri || e_rd) && !e_iw) begin
      pend.push_back(rd_t'{e_ri ? 1 : 2, mem_arr[e_ea[9:0]]});
      mq.push_back(mret_t'{cyc + lat, mem_arr[e_ea[9:0]]});
    end else if (e_ri || e_rd) begin
      mem_arr[e_ea[9:0]] = e_ewd;
    end
    if (holder == 0) begin
      if (bus.i_req && bus.d_req) pick = (last == 1) ? 2 : 1;
      else if (bus.d_req)         pick = 2;
      else if (bus.i_req)         pick = 1;
      else                        pick = 0;
      if (pick != 0) begin
        holder = pick;
        last   = pick;
      end
    end else if (!draining) begin
      own_req = (holder == 1) ? bus.i_req : bus.d_req;
      if (!own_req) begin
        if (e_cnt == 0) holder = 0;
        else            draining = 1'b1;
      end
    end else if (e_cnt == 0) begin
      holder   = 0;
      draining = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(input int n = 1);
    for (int s = 0; s < n; s++) begin
      eval();
      advance();
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    inject = 1'b0;
    #1;
    chk("rst_i_grant", bus.i_grant, 1'b0);
    chk("rst_d_grant", bus.d_grant, 1'b0);
    chk("rst_i_ready", bus.i_ready, 1'b0);
    chk("rst_d_ready", bus.d_ready, 1'b0);
    chk("rst_mem_enable", bus.mem_enable, 1'b0);
    chk("rst_mem_wr", bus.mem_wr, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_data_in", bus.mem_data_in, 16'h0000);
    chk("rst_i_rvalid", bus.i_rvalid, 1'b0);
    chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    holder   = 0;
    draining = 1'b0;
    last     = 1;
    err_m    = 1'b0;
    pend.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, stall, rv0;
    bus.i_req = 0; bus.i_wr = 0; bus.i_addr = 0; bus.i_wdata = 0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_data_valid = 0; bus.mem_data_out = 0;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 16'($urandom);

    @(negedge clk);
    do_reset();

    // T1: single D read, 4-cycle memory latency
    mem_arr[16] = 16'hBEEF;
    bus.d_req = 1; bus.d_addr = 16'h0010;
    step();
    eval();
    chk("t1_grant", bus.d_grant, 1'b1);
    chk("t1_addr", bus.mem_addr, 16'h0010);
    advance();
    bus.d_req = 0;
    step(3);
    eval();
    chk("t1_rvalid", bus.d_rvalid, 1'b1);
    chk("t1_rdata", bus.d_rdata, 16'hBEEF);
    chk("t1_i_rvalid", bus.i_rvalid, 1'b0);
    advance();
    step(3);

    // T2: 8-word fill with a slower memory so the pipeline fills and stalls
    lat = 6;
    for (int a = 0; a < 8; a++) mem_arr[10'h100 + 10'(2*a)] = 16'hD000 + 16'(a);
    rv0 = rvd; k = 0; stall = 0;
    bus.d_req = 1; bus.d_wr = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      bus.d_addr = 16'h0100 + 16'(2*k);
      eval();
      if (e_rd) k++;
      if (bus.d_grant === 1'b1 && bus.d_ready === 1'b0) stall++;
      advance();
    end
    chk("t2_issued", 16'(k), 16'd8);
    chk("t2_stalled", 16'(stall != 0), 16'd1);
    bus.d_req = 0;
    step(12);
    chk("t2_rvalid_count", 16'(rvd - rv0), 16'd8);
    lat = 4;

    // T3: contention from reset, alternation through the IDLE bubble
    do_reset();
    bus.i_wr = 1; bus.d_wr = 1; bus.i_addr = 16'h0030; bus.d_addr = 16'h0040;
    bus.i_req = 1; bus.d_req = 1;
    step();
    eval();
    chk("t3_d_first", bus.d_grant, 1'b1);
    chk("t3_i_waits", bus.i_grant, 1'b0);
    advance();
    bus.d_req = 0;
    step();
    eval();
    chk("t3_bubble", {bus.i_grant, bus.d_grant}, 16'd0);
    advance();
    eval();
    chk("t3_i_next", bus.i_grant, 1'b1);
    advance();
    bus.i_req = 0;
    step(2);
    bus.i_req = 1; bus.d_req = 1;
    step();
    eval();
    chk("t3_d_again", bus.d_grant, 1'b1);
    advance();
    bus.i_req = 0; bus.d_req = 0; bus.i_wr = 0; bus.d_wr = 0;
    step(2);

    // T4: I drains 3 reads while D waits
    rv0 = rvi;
    bus.i_req = 1;
    step();
    for (int a = 0; a < 3; a++) begin
      bus.i_addr = 16'h0020 + 16'(2*a);
      step();
    end
    bus.i_req = 0; bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0050;
    for (int c = 0; c < 5; c++) begin
      eval();
      chk("t4_no_d_grant", bus.d_grant, 1'b0);
      advance();
    end
    step();
    eval();
    chk("t4_d_grant", bus.d_grant, 1'b1);
    advance();
    chk("t4_i_rvalid_count", 16'(rvi - rv0), 16'd3);
    bus.d_req = 0; bus.d_wr = 0;
    step(2);

    // T5: single D write
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
    step();
    eval();
    chk("t5_mem_wr", bus.mem_wr, 1'b1);
    chk("t5_addr", bus.mem_addr, 16'h0200);
    chk("t5_data", bus.mem_data_in, 16'h1234);
    advance();
    bus.d_req = 0; bus.d_wr = 0;
    eval();
    chk("t5_wr_once", bus.mem_wr, 1'b0);
    advance();
    step(3);

    // T6: reset with reads in flight, then a stray valid while owning
    bus.i_req = 1; bus.i_addr = 16'h0060;
    step(3);
    do_reset();
    bus.i_req = 0;
    step(6);
    chk("t6_err_clear", bus.err, 1'b0);
    bus.i_req = 1; bus.i_wr = 1;
    step();
    inject = 1;
    eval();
    advance();
    inject = 0;
    eval();
    chk("t6_err_set", bus.err, 1'b1);
    advance();
    bus.i_req = 0; bus.i_wr = 0;
    step(4);
    chk("t6_err_sticky", bus.err, 1'b1);

    // Random traffic
    do_reset();
    step(10);
    lat = 4 + int'($urandom_range(0, 2));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.i_req = ~bus.i_req;
      if ($urandom_range(0, 7) == 0) bus.d_req = ~bus.d_req;
      bus.i_wr    = ($urandom_range(0, 5) == 0);
      bus.d_wr    = ($urandom_range(0, 5) == 0);
      bus.i_addr  = {6'd0, 9'($urandom), 1'b0};
      bus.d_addr  = {6'd0, 9'($urandom), 1'b0};
      bus.i_wdata = 16'($urandom);
      bus.d_wdata = 16'($urandom);
      step();
    end
    bus.i_req = 0; bus.d_req = 0;
    step(12);
    chk("rand_no_err", bus.err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
